// File: rtl/dmem_pkg.sv
// Shared encodings and sizing helpers for the byte-addressed data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic int lane_count(int dw);
    return dw / 8;
  endfunction

  function automatic int offset_width(int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering: byte enables and shifted store data, load extraction with
// sign/zero extension, and misalignment / illegal-size detection.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = lane_count(DATA_W),
  parameter int OFF_W  = offset_width(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] raw,
  input  logic [DATA_W-1:0] wdata,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              err
);

  localparam int MSB_W = $clog2(DATA_W);

  logic [3:0]        nbytes;
  logic [6:0]        width;
  logic [MSB_W-1:0]  msb;
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sh;

  always_comb begin
    nbytes = 4'd1 << size;
    err    = ((4'(offset) & (nbytes - 4'd1)) != 4'd0) ||
             (size == SZ_DWORD && DATA_W == 32);
    width  = (nbytes == 4'd8 && DATA_W == 32) ? 7'd32 : {nbytes, 3'b000};
    msb    = MSB_W'(width - 7'd1);

    for (int unsigned i = 0; i < LANES; i++) begin
      be[i] = !err && (i >= 32'(offset)) && (i < 32'(offset) + 32'(nbytes));
    end

    wdata_sh = wdata << {offset, 3'b000};
    sh       = raw >> {offset, 3'b000};

    // Full-width accesses get an all-ones mask, so the sign fill is a no-op.
    ones = '1;
    mask = (32'(width) >= DATA_W) ? ones : ~(ones << width);

    rdata_ext = '0;
    if (!err) begin
      rdata_ext = sh & mask;
      if (!is_unsigned && sh[msb]) begin
        rdata_ext = rdata_ext | ~mask;
      end
    end
  end

endmodule

// File: rtl/dmem.sv
// Single-port data memory with power-on clear, size-aware load/store and a
// fixed-latency, in-order response pipeline.
module dmem
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = $clog2(DEPTH) + $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int LANES = lane_count(DATA_W);
  localparam int OFF_W = offset_width(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [IDX_W-1:0]  widx;
  logic [OFF_W-1:0]  offset;
  logic              accept;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] rdata_ext;
  logic              err;

  // Stage 0 captures the access result at the acceptance edge; stages
  // 1..RD_LAT form the delay line whose last stage drives the outputs.
  logic              pv [RD_LAT+1];
  logic              pe [RD_LAT+1];
  logic [DATA_W-1:0] pd [RD_LAT+1];

  assign widx   = req_addr[ADDR_W-1:OFF_W];
  assign offset = req_addr[OFF_W-1:0];
  assign accept = req_valid && req_ready;
  assign raw    = mem[widx];

  dmem_align #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .OFF_W  (OFF_W)
  ) u_align (
    .size        (req_size),
    .offset      (offset),
    .is_unsigned (req_unsigned),
    .raw         (raw),
    .wdata       (req_wdata),
    .be          (be),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext),
    .err         (err)
  );

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (accept && req_we && !err) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_ptr   <= '0;
      req_ready <= 1'b0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end
        end
        default: req_ready <= 1'b1;
      endcase

      pv[0] <= accept;
      pe[0] <= accept && err;
      pd[0] <= (accept && !req_we && !err) ? rdata_ext : '0;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign resp_valid = pv[RD_LAT];
  assign resp_err   = pe[RD_LAT];
  assign resp_rdata = pd[RD_LAT];

endmodule

// File: tb/tb_dmem.sv
// Bench for dmem: directed vector table, back-to-back and reset sequences,
// plus randomized traffic checked by a byte-array reference model.
module tb_dmem;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  dmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t       sbq[$];
  exp_t       sb_e;
  int         cyc = 0;
  logic [7:0] bmem [4096];

  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [11:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          n;
    int          a;
    logic [63:0] v;
    n       = 1 << sz;
    a       = int'(addr);
    e.due   = cyc + RD_LAT;
    e.err   = (sz == 2'd3) || (a % n != 0);
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        for (int k = 0; k < n; k++) bmem[a+k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(bmem[a+k]) << (8*k));
        if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      foreach (bmem[i]) bmem[i] = 8'h00;
    end else if (req_valid && req_ready) begin
      sbq.push_back(model(req_we, req_size, req_unsigned, req_addr, req_wdata));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      sb_e = sbq.pop_front();
      check("sb_valid", 64'(resp_valid), 64'd1);
      check("sb_err",   64'(resp_err),   64'(sb_e.err));
      check("sb_rdata", 64'(resp_rdata), 64'(sb_e.rdata));
    end else if (resp_valid) begin
      check("sb_spurious_valid", 64'(resp_valid), 64'd0);
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [15];

  task automatic drive(input vec_t v);
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
  endtask

  task automatic do_req(input vec_t v, output logic err, output logic [31:0] rd, output int lat);
    @(negedge clk);
    drive(v);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    err = resp_err;
    rd  = resp_rdata;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n), 64'(DEPTH));
  endtask

  logic        g_err;
  logic [31:0] g_rd;
  int          g_lat;
  vec_t        seq [17];
  logic [31:0] got [$];
  int          first_v, last_v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    size   uns   addr     wdata         err   rdata
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 12'h3FC, 32'h0,        1'b0, 32'h00000000};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 12'h100, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[2]  = '{1'b0, 2'b10, 1'b0, 12'h100, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 12'h101, 32'h00000081, 1'b0, 32'h00000000};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 12'h101, 32'h0,        1'b0, 32'hFFFFFF81};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 12'h101, 32'h0,        1'b0, 32'h00000081};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 12'h100, 32'h0,        1'b0, 32'hDEAD81EF};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 12'h102, 32'h0,        1'b0, 32'hFFFFDEAD};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 12'h103, 32'h0,        1'b1, 32'h00000000};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 12'h102, 32'h12345678, 1'b1, 32'h00000000};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 12'h100, 32'h0,        1'b0, 32'hDEAD81EF};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 12'h100, 32'h0,        1'b1, 32'h00000000};
    tbl[12] = '{1'b0, 2'b01, 1'b1, 12'h100, 32'h0,        1'b0, 32'h000081EF};
    tbl[13] = '{1'b1, 2'b01, 1'b0, 12'h202, 32'h12348001, 1'b0, 32'h00000000};
    tbl[14] = '{1'b0, 2'b10, 1'b0, 12'h200, 32'h0,        1'b0, 32'h80010000};

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready),  64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(resp_rdata), 64'd0);
    check("rst_err",   64'(resp_err),   64'd0);
    rst_n = 1'b1;
    wait_ready("init_cycles");

    foreach (tbl[i]) begin
      do_req(tbl[i], g_err, g_rd, g_lat);
      check($sformatf("vec%0d_lat", i),   64'(g_lat), 64'(RD_LAT));
      check($sformatf("vec%0d_err", i),   64'(g_err), 64'(tbl[i].exp_err));
      check($sformatf("vec%0d_rdata", i), 64'(g_rd),  64'(tbl[i].exp_rdata));
    end

    // Store then immediate load, more stores, then 8 back-to-back loads.
    seq[0] = '{1'b1, 2'b10, 1'b0, 12'h200, 32'h1, 1'b0, 32'h0};
    seq[1] = '{1'b0, 2'b10, 1'b0, 12'h200, 32'h0, 1'b0, 32'h1};
    for (int k = 1; k < 8; k++)
      seq[1+k] = '{1'b1, 2'b10, 1'b0, 12'(12'h200 + 4*k), 32'(k+1), 1'b0, 32'h0};
    for (int k = 0; k < 8; k++)
      seq[9+k] = '{1'b0, 2'b10, 1'b0, 12'(12'h200 + 4*k), 32'h0, 1'b0, 32'(k+1)};
    first_v = -1;
    last_v  = -1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got.push_back(resp_rdata);
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (i < 17) drive(seq[i]);
      else req_valid = 1'b0;
    end
    check("b2b_count", 64'(got.size()), 64'd17);
    check("b2b_contiguous", 64'(last_v - first_v + 1), 64'd17);
    if (got.size() == 17) begin
      check("raw_next_cycle", 64'(got[1]), 64'd1);
      for (int k = 0; k < 8; k++)
        check($sformatf("b2b_load%0d", k), 64'(got[9+k]), 64'(k+1));
    end

    // Reset with loads in flight.
    @(negedge clk);
    drive(tbl[6]);
    @(negedge clk);
    drive(tbl[6]);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_first_resp", 64'(resp_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_rdata", 64'(resp_rdata), 64'd0);
    check("mid_rst_ready", 64'(req_ready),  64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 64'(resp_valid), 64'd0);
    end
    rst_n = 1'b1;
    wait_ready("reinit_cycles");
    do_req(tbl[2], g_err, g_rd, g_lat);
    check("reinit_lat",   64'(g_lat), 64'(RD_LAT));
    check("reinit_rdata", 64'(g_rd),  64'd0);

    // Randomized traffic; the scoreboard checks every response.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid    = ($urandom_range(0, 3) != 0);
      req_we       = $urandom_range(0, 1) == 1;
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = $urandom_range(0, 1) == 1;
      req_addr     = 12'($urandom_range(0, 255));
      req_wdata    = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (RD_LAT + 3) @(negedge clk);
    check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
